// File: rtl/ft232h_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ft232h_pkg
// Description : Shared constants for the FT232H 245 synchronous FIFO
//               responder: bus width, sticky error bit positions and the
//               LFSR used by the FT232H_RESP_THROTTLE_EN flag throttle.
// Revision    : 1.0 - initial release
// ============================================================================
package ft232h_pkg;

    localparam int FT_DATA_W = 8;

    // Positions of the sticky error bits in err_o
    localparam int ERR_RD   = 0;   // RD# low while RXF# high
    localparam int ERR_WR   = 1;   // WR# low while TXE# high
    localparam int ERR_CONT = 2;   // OE# and WR# low together (bus contention)

    // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One LFSR step: shift left, feedback is the XOR of the tapped bits
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage : ft232h_pkg
`default_nettype wire

// File: rtl/ft232h_sfifo.sv
`default_nettype none
// ============================================================================
// Module      : ft232h_sfifo
// Description : Single-clock show-ahead FIFO. Besides the usual pointers it
//               exposes the head and the occupancy as they will be after the
//               current edge, so the owner can keep fully registered flags
//               and a registered head byte that already reflect this edge.
//               The caller never pushes when full nor pops when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ft232h_sfifo #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_next_o,
    output logic [AW:0]   count_next_o
);

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   count_after_pop;

    // Next pointers, next occupancy and the head byte after this edge
    always_comb begin
        wr_ptr_d        = wr_ptr_q + AW'(push_i);
        rd_ptr_d        = rd_ptr_q + AW'(pop_i);
        count_after_pop = count_q - (AW+1)'(pop_i);
        count_d         = count_after_pop + (AW+1)'(push_i);
        // Nothing left after the pop: the new head is the byte being written
        if (count_after_pop == '0) begin
            head_next_o = wdata_i;
        end else begin
            head_next_o = mem[rd_ptr_d];
        end
        count_next_o = count_d;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset so it maps onto block RAM
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

endmodule : ft232h_sfifo
`default_nettype wire

// File: rtl/ft232h_fifo_responder.sv
`default_nettype none
// ============================================================================
// Module      : ft232h_fifo_responder
// Description : Chip-side model of the FT232H 245 synchronous FIFO bus.
//               Host bytes (H2D) are buffered and served to the master on
//               RD#/OE#; master writes on WR# are buffered toward the host
//               (D2H). All flags and bus outputs are registered.
//               Optional macro FT232H_RESP_THROTTLE_EN: an LFSR randomly
//               forces RXF#/TXE# high to stress the master's flag handling.
// Revision    : 1.0 - initial release
// ============================================================================
module ft232h_fifo_responder
    import ft232h_pkg::*;
#(
    parameter int H2D_AW = 9,
    parameter int D2H_AW = 9,
    parameter int CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst,
    input  logic                 usb_rd_n_i,
    input  logic                 usb_wr_n_i,
    input  logic                 usb_oe_n_i,
    input  logic [FT_DATA_W-1:0] usb_data_i,
    output logic [FT_DATA_W-1:0] usb_data_o,
    output logic                 usb_data_oe_o,
    output logic                 usb_rxf_n_o,
    output logic                 usb_txe_n_o,
    input  logic                 h2d_valid_i,
    input  logic [FT_DATA_W-1:0] h2d_data_i,
    output logic                 h2d_ready_o,
    output logic                 d2h_valid_o,
    output logic [FT_DATA_W-1:0] d2h_data_o,
    input  logic                 d2h_ready_i,
    output logic [CNT_W-1:0]     h2d_cnt_o,
    output logic [CNT_W-1:0]     d2h_cnt_o,
    output logic [2:0]           err_o
);

    localparam logic [H2D_AW:0] C_H2D_DEPTH = {1'b1, {H2D_AW{1'b0}}};
    localparam logic [D2H_AW:0] C_D2H_DEPTH = {1'b1, {D2H_AW{1'b0}}};

    logic                 rxf_n_q, rxf_n_d;
    logic                 txe_n_q, txe_n_d;
    logic                 data_oe_q, data_oe_d;
    logic [FT_DATA_W-1:0] usb_data_q, usb_data_d;
    logic                 h2d_ready_q, h2d_ready_d;
    logic                 d2h_valid_q, d2h_valid_d;
    logic [FT_DATA_W-1:0] d2h_data_q, d2h_data_d;
    logic [CNT_W-1:0]     h2d_cnt_q, h2d_cnt_d;
    logic [CNT_W-1:0]     d2h_cnt_q, d2h_cnt_d;
    logic [2:0]           err_q, err_d;

    logic                 h2d_push, h2d_pop;
    logic                 d2h_push, d2h_pop;
    logic [FT_DATA_W-1:0] h2d_head_next, d2h_head_next;
    logic [H2D_AW:0]      h2d_count_next;
    logic [D2H_AW:0]      d2h_count_next;
    logic                 throttle;

`ifdef FT232H_RESP_THROTTLE_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Free-running LFSR; its next bit 0 gates the flags for the coming cycle
    always_comb begin
        lfsr_d   = lfsr_step(lfsr_q);
        throttle = lfsr_d[0];
    end

    // LFSR state register
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign throttle = 1'b0;
`endif

    // Bus handshake decode against the registered flags the master sees
    always_comb begin
        h2d_push = h2d_valid_i && h2d_ready_q;
        h2d_pop  = !usb_rd_n_i && !usb_oe_n_i && !rxf_n_q;
        d2h_push = !usb_wr_n_i && usb_oe_n_i && !txe_n_q;
        d2h_pop  = d2h_valid_q && d2h_ready_i;
    end

    ft232h_sfifo #(
        .AW (H2D_AW),
        .DW (FT_DATA_W)
    ) u_h2d_fifo (
        .clk_i        (clk_i),
        .rst          (rst),
        .push_i       (h2d_push),
        .wdata_i      (h2d_data_i),
        .pop_i        (h2d_pop),
        .head_next_o  (h2d_head_next),
        .count_next_o (h2d_count_next)
    );

    ft232h_sfifo #(
        .AW (D2H_AW),
        .DW (FT_DATA_W)
    ) u_d2h_fifo (
        .clk_i        (clk_i),
        .rst          (rst),
        .push_i       (d2h_push),
        .wdata_i      (usb_data_i),
        .pop_i        (d2h_pop),
        .head_next_o  (d2h_head_next),
        .count_next_o (d2h_count_next)
    );

    // Next-state for flags, heads, counters and sticky errors
    always_comb begin
        rxf_n_d     = (h2d_count_next == '0) || throttle;
        txe_n_d     = (d2h_count_next == C_D2H_DEPTH) || throttle;
        h2d_ready_d = (h2d_count_next != C_H2D_DEPTH);
        d2h_valid_d = (d2h_count_next != '0);
        data_oe_d   = !usb_oe_n_i;
        // Heads hold their last value when the buffer drains
        usb_data_d  = (h2d_count_next != '0) ? h2d_head_next : usb_data_q;
        d2h_data_d  = (d2h_count_next != '0) ? d2h_head_next : d2h_data_q;
        h2d_cnt_d   = h2d_cnt_q + CNT_W'(h2d_pop);
        d2h_cnt_d   = d2h_cnt_q + CNT_W'(d2h_push);
        err_d       = err_q;
        if (!usb_rd_n_i && rxf_n_q) begin
            err_d[ERR_RD] = 1'b1;
        end
        if (!usb_wr_n_i && txe_n_q) begin
            err_d[ERR_WR] = 1'b1;
        end
        if (!usb_wr_n_i && !usb_oe_n_i) begin
            err_d[ERR_CONT] = 1'b1;
        end
    end

    // Output registers; async clear releases the bus immediately
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            rxf_n_q     <= 1'b1;
            txe_n_q     <= 1'b1;
            data_oe_q   <= 1'b0;
            usb_data_q  <= '0;
            h2d_ready_q <= 1'b0;
            d2h_valid_q <= 1'b0;
            d2h_data_q  <= '0;
            h2d_cnt_q   <= '0;
            d2h_cnt_q   <= '0;
            err_q       <= '0;
        end else begin
            rxf_n_q     <= rxf_n_d;
            txe_n_q     <= txe_n_d;
            data_oe_q   <= data_oe_d;
            usb_data_q  <= usb_data_d;
            h2d_ready_q <= h2d_ready_d;
            d2h_valid_q <= d2h_valid_d;
            d2h_data_q  <= d2h_data_d;
            h2d_cnt_q   <= h2d_cnt_d;
            d2h_cnt_q   <= d2h_cnt_d;
            err_q       <= err_d;
        end
    end

    assign usb_rxf_n_o   = rxf_n_q;
    assign usb_txe_n_o   = txe_n_q;
    assign usb_data_oe_o = data_oe_q;
    assign usb_data_o    = usb_data_q;
    assign h2d_ready_o   = h2d_ready_q;
    assign d2h_valid_o   = d2h_valid_q;
    assign d2h_data_o    = d2h_data_q;
    assign h2d_cnt_o     = h2d_cnt_q;
    assign d2h_cnt_o     = d2h_cnt_q;
    assign err_o         = err_q;

endmodule : ft232h_fifo_responder
`default_nettype wire

// File: doc/ft232h_fifo_responder.md
Name: ft232h_fifo_responder

Overview:
Synthesizable model of the FT232H chip side of the 245 synchronous FIFO bus. It drives RXF#/TXE# and read data, and it samples RD#/WR#/OE# and write data. It is used in the loopback test fixture and in the hardware self-test build to exercise the FPGA-side USB bridge without a PC. Host-side traffic enters and leaves through two byte streams: H2D, standing in for "PC sends", and D2H, standing in for "PC receives".

Parameters:
H2D_AW, 9, log2 depth of the host-to-device buffer (512 bytes)
D2H_AW, 9, log2 depth of the device-to-host buffer (512 bytes)
CNT_W, 16, width of the byte counters

Ports:
clk_i  in  1  FIFO bus clock; the same clock is forwarded to the master as usb_clk
rst  in  1  asynchronous reset, active-high
usb_rd_n_i  in  1  RD# from master
usb_wr_n_i  in  1  WR# from master
usb_oe_n_i  in  1  OE# from master
usb_data_i  in  8  bus data from master (write data)
usb_data_o  out  8  bus data to master (read data)
usb_data_oe_o  out  1  high = responder drives the bus
usb_rxf_n_o  out  1  RXF#: low = H2D data available
usb_txe_n_o  out  1  TXE#: low = D2H space available
h2d_valid_i  in  1  host byte valid
h2d_data_i  in  8  host byte
h2d_ready_o  out  1  H2D buffer not full
d2h_valid_o  out  1  D2H byte available
d2h_data_o  out  8  D2H byte (show-ahead)
d2h_ready_i  in  1  host consumes a D2H byte
h2d_cnt_o  out  CNT_W  bytes delivered to the master (wraps)
d2h_cnt_o  out  CNT_W  bytes accepted from the master (wraps)
err_o  out  3  sticky: [0] RD# while RXF# high, [1] WR# while TXE# high, [2] OE# and WR# low together

Behaviour:
- All logic is on posedge clk_i; rst clears state asynchronously. The master operates on the negedge.
- Reset values: usb_rxf_n_o=1, usb_txe_n_o=1, usb_data_oe_o=0, usb_data_o=0, h2d_ready_o=0, d2h_valid_o=0, counters=0, err_o=0, both buffers empty.
- On the first edge after reset release: usb_txe_n_o=0 and h2d_ready_o=1.
- H2D push: on each edge with h2d_valid_i && h2d_ready_o. h2d_ready_o is low when the buffer is full.
- usb_data_oe_o: registered copy of ~usb_oe_n_i, so there is one cycle of turnaround.
- usb_data_o: H2D head (show-ahead). It updates on the edge after a pop.
- H2D pop: on an edge with rd_n=0 && oe_n=0 && rxf_n_o=0. The pop increments h2d_cnt_o.
- usb_rxf_n_o: registered; high iff the H2D count after this edge's push/pop is 0.
  - A push and pop on the same edge leave the count unchanged.
- The RD#-without-OE# condition is ignored without an error.
- RD# low while usb_rxf_n_o=1: no pop; sets err_o[0].
- D2H push: on an edge with wr_n=0 && txe_n_o=0 && oe_n=1. It captures usb_data_i and increments d2h_cnt_o.
- usb_txe_n_o: registered; high iff the D2H count after this edge's push/pop equals the depth.
  - Because the flag is registered, any write accepted while txe_n_o=0 always fits.
- WR# low while usb_txe_n_o=1: byte dropped; sets err_o[1].
- WR# and OE# both low on the same edge: byte dropped; sets err_o[2].
- D2H pop: on d2h_valid_o && d2h_ready_i. d2h_valid_o = D2H not empty.
- Counters wrap modulo 2^CNT_W. err_o bits clear only on rst.
- Reset mid-transfer: the bus is released immediately (asynchronous clear) and buffered bytes are discarded.

Optional Feature:
FT232H_RESP_THROTTLE_EN:
- Defined: a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11, advancing every cycle) forces usb_rxf_n_o and usb_txe_n_o high for any cycle whose LFSR bit 0 is 1, ORed with the normal conditions. This stresses master flag handling. The buffer logic is unchanged.
- Undefined: flags follow buffer state only, and the LFSR is absent.

Decomposition:
- Package ft232h_pkg: FT_DATA_W=8, error-bit index constants (ERR_RD, ERR_WR, ERR_CONT), LFSR seed/taps.
- One sub-module: ft232h_sfifo, a single-clock show-ahead FIFO with AW parameter and count output. It is instantiated twice (H2D, D2H).

Test Plan:
1. Reset release -> rxf_n=1, txe_n=0 on first edge; push 3 bytes 8'h11,8'h22,8'h33 on H2D -> rxf_n=0 one edge after the first push.
2. Master asserts OE#, then holds RD# low for 3 cycles -> master receives 11,22,33; rxf_n=1 after the third pop; h2d_cnt_o=3; err_o=0.
3. Master writes 512 bytes 0..255,0..255 with d2h_ready_i=0 -> txe_n=1 after the 512th; a 513th WR# is dropped with err_o[1]=1; draining D2H yields the exact sequence; d2h_cnt_o=512.
4. RD# low with H2D empty -> no data change; err_o[0]=1. OE# and WR# low together -> err_o[2]=1; D2H count unchanged.
5. Assert rst mid-burst (after 100 of 200 writes) -> data_oe=0, flags=1, counters=0 at once; after release txe_n=0 and D2H is empty.
6. FT232H_RESP_THROTTLE_EN defined, 1000-byte loopback through the master bridge -> all bytes in order, err_o=0, flags deasserted on the LFSR pattern.
